// File: rtl/hid_pkg.sv
// -----------------------------------------------------------------------------
// hid_pkg
// Shared definitions for the UART HID text decoder: HID type codes, the byte
// count each report type carries, the ASCII characters the line grammar uses,
// the parser and receiver state encodings, and small character helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package hid_pkg;

    // HID type codes, identical to the USB host core's typ encoding
    localparam logic [1:0] TYP_NONE  = 2'd0;
    localparam logic [1:0] TYP_KBD   = 2'd1;
    localparam logic [1:0] TYP_MOUSE = 2'd2;
    localparam logic [1:0] TYP_GAME  = 2'd3;

    // Payload bytes per report type; the line buffer is sized for the largest
    localparam logic [2:0] KBD_BYTES   = 3'd5;
    localparam logic [2:0] MOUSE_BYTES = 3'd3;
    localparam logic [2:0] GAME_BYTES  = 3'd2;
    localparam int         MAX_BYTES   = 5;

    // ASCII characters with a meaning in the line grammar
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_M  = 8'h4D;
    localparam logic [7:0] ASCII_G  = 8'h47;

    // Line parser states. ST_TYPE mirrors the HID printer's state list; the
    // type character is decoded directly in ST_IDLE, so the parser never rests
    // in ST_TYPE and treats it like ST_IDLE if it ever finds itself there.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_DATA,
        ST_SKIP
    } parse_state_t;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    function automatic logic is_term(input logic [7:0] c);
        return (c == ASCII_CR) || (c == ASCII_LF);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters A-F and a-f share their low nibble (1..6), so adding 9 yields 10..15
    function automatic logic [3:0] hex_val(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : (c[3:0] + 4'd9);
    endfunction

    // Clearing bit 5 folds lower-case letters onto upper case
    function automatic logic [1:0] decode_type(input logic [7:0] c);
        logic [7:0] up;
        up = c & 8'hDF;
        if (up == ASCII_K)      return TYP_KBD;
        else if (up == ASCII_M) return TYP_MOUSE;
        else if (up == ASCII_G) return TYP_GAME;
        else                    return TYP_NONE;
    endfunction

    function automatic logic [2:0] type_bytes(input logic [1:0] t);
        case (t)
            TYP_KBD:   return KBD_BYTES;
            TYP_MOUSE: return MOUSE_BYTES;
            TYP_GAME:  return GAME_BYTES;
            default:   return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver: two-flop synchroniser, start-bit glitch rejection,
// mid-bit sampling of 8 data bits LSB first, stop bit check.
// Ports:
//   clk         in   clock
//   resetn      in   async active-low reset
//   uart_rx     in   serial input, idle high, asynchronous to clk
//   data        out  8  last received byte (valid while byte_valid is high)
//   byte_valid  out  1  one-cycle pulse, byte received with a good stop bit
//   frame_err   out  1  one-cycle pulse, stop bit read low
// -----------------------------------------------------------------------------
module uart_rx_byte
    import hid_pkg::*;
#(
    parameter int BIT_CYC = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW   = $clog2(BIT_CYC + 1);
    localparam int HALF = BIT_CYC / 2;

    logic [1:0]      r_sync;
    logic            r_rxPrev;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_shift;
    logic            w_rx;
    logic            w_fall;

    // Bring the asynchronous line into the clock domain and keep one more
    // delayed copy for falling-edge detection. Reset to the idle level so
    // release from reset does not look like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync   <= 2'b11;
            r_rxPrev <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], uart_rx};
            r_rxPrev <= r_sync[1];
        end
    end

    assign w_rx   = r_sync[1];
    assign w_fall = r_rxPrev & ~w_rx;

    // Bit timer and shifter. The start bit is re-checked half a bit after the
    // edge; every later sample is a full bit period after the previous one,
    // which lands each sample near the middle of its bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= CW'(HALF - 1);
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx) begin
                        r_state <= RX_IDLE;
                    end else begin
                        r_cnt    <= CW'(BIT_CYC - 1);
                        r_bitIdx <= '0;
                        r_state  <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift  <= {w_rx, r_shift[7:1]};
                        r_cnt    <= CW'(BIT_CYC - 1);
                        r_bitIdx <= r_bitIdx + 1'b1;
                        if (r_bitIdx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (w_rx) begin
                            data       <= r_shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_hid_decoder.sv
// -----------------------------------------------------------------------------
// uart_hid_decoder
// Parses HID report text lines ("<K|M|G> hex bytes <CR|LF>") arriving on a
// UART pin and drives the same HID output bundle as the USB host core.
// Build option: define LINE_TIMEOUT_EN to drop a partial line after
// TIMEOUT_CYC idle cycles; undefined, a partial line waits for its terminator.
// Ports:
//   clk, resetn               clock and async active-low reset
//   uart_rx                   serial input, 8N1, idle high
//   typ                       type of the last committed line
//   report                    one-cycle pulse on commit
//   err                       one-cycle pulse when a line is discarded
//   key_modifiers, key1..key4 keyboard fields
//   mouse_btn, mouse_dx/dy    mouse fields (dx/dy signed)
//   game_l .. game_sta        gamepad buttons
// -----------------------------------------------------------------------------
module uart_hid_decoder
    import hid_pkg::*;
#(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 1_200_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              uart_rx,
    output logic [1:0]        typ,
    output logic              report,
    output logic              err,
    output logic [7:0]        key_modifiers,
    output logic [7:0]        key1,
    output logic [7:0]        key2,
    output logic [7:0]        key3,
    output logic [7:0]        key4,
    output logic [7:0]        mouse_btn,
    output logic signed [7:0] mouse_dx,
    output logic signed [7:0] mouse_dy,
    output logic              game_l,
    output logic              game_r,
    output logic              game_u,
    output logic              game_d,
    output logic              game_a,
    output logic              game_b,
    output logic              game_x,
    output logic              game_y,
    output logic              game_sel,
    output logic              game_sta
);

    localparam int BIT_CYC = (CLK_FREQ + BAUD / 2) / BAUD;

    logic [7:0]   w_data;
    logic         w_byteValid;
    logic         w_frameErr;
    logic         w_timeout;

    parse_state_t r_state;
    logic [1:0]   r_lineTyp;
    logic [2:0]   r_byteCnt;
    logic         r_haveHi;
    logic [3:0]   r_hiNib;
    logic [7:0]   r_buf [MAX_BYTES];

    uart_rx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_rx (
        .clk        (clk),
        .resetn     (resetn),
        .uart_rx    (uart_rx),
        .data       (w_data),
        .byte_valid (w_byteValid),
        .frame_err  (w_frameErr)
    );

`ifdef LINE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_toCnt;

    // Idle-line counter: restarts on every received byte and sits at zero
    // outside a line, then saturates so the timeout fires once per line.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_toCnt <= '0;
        end else if (w_byteValid || (r_state == ST_IDLE)) begin
            r_toCnt <= '0;
        end else if (r_toCnt != TW'(TIMEOUT_CYC)) begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    assign w_timeout = (r_toCnt == TW'(TIMEOUT_CYC));
`else
    // No idle counter in this build; the comparison is constant false
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    // Line parser and output registers. Received bytes take priority over the
    // timeout; report and err are set in mutually exclusive branches so they
    // can never pulse together. Commit happens on the terminator's byte, so
    // the new fields and report appear in the following cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_lineTyp     <= TYP_NONE;
            r_byteCnt     <= '0;
            r_haveHi      <= 1'b0;
            r_hiNib       <= '0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                r_buf[i] <= '0;
            end
            typ           <= TYP_NONE;
            report        <= 1'b0;
            err           <= 1'b0;
            key_modifiers <= '0;
            key1          <= '0;
            key2          <= '0;
            key3          <= '0;
            key4          <= '0;
            mouse_btn     <= '0;
            mouse_dx      <= '0;
            mouse_dy      <= '0;
            game_l        <= 1'b0;
            game_r        <= 1'b0;
            game_u        <= 1'b0;
            game_d        <= 1'b0;
            game_a        <= 1'b0;
            game_b        <= 1'b0;
            game_x        <= 1'b0;
            game_y        <= 1'b0;
            game_sel      <= 1'b0;
            game_sta      <= 1'b0;
        end else begin
            report <= 1'b0;
            err    <= 1'b0;
            if (w_frameErr) begin
                // A line already being skipped has been reported once
                if (r_state != ST_SKIP) begin
                    err <= 1'b1;
                end
                r_state <= ST_SKIP;
            end else if (w_byteValid) begin
                case (r_state)
                    ST_DATA: begin
                        if (w_data == ASCII_SP) begin
                            r_state <= ST_DATA;
                        end else if (is_hex(w_data)) begin
                            if (!r_haveHi) begin
                                if (r_byteCnt == 3'(MAX_BYTES)) begin
                                    err     <= 1'b1;
                                    r_state <= ST_SKIP;
                                end else begin
                                    r_hiNib  <= hex_val(w_data);
                                    r_haveHi <= 1'b1;
                                end
                            end else begin
                                r_buf[r_byteCnt] <= {r_hiNib, hex_val(w_data)};
                                r_byteCnt        <= r_byteCnt + 1'b1;
                                r_haveHi         <= 1'b0;
                            end
                        end else if (is_term(w_data)) begin
                            if (!r_haveHi && (r_byteCnt == type_bytes(r_lineTyp))) begin
                                typ    <= r_lineTyp;
                                report <= 1'b1;
                                case (r_lineTyp)
                                    TYP_KBD: begin
                                        key_modifiers <= r_buf[0];
                                        key1          <= r_buf[1];
                                        key2          <= r_buf[2];
                                        key3          <= r_buf[3];
                                        key4          <= r_buf[4];
                                    end
                                    TYP_MOUSE: begin
                                        mouse_btn <= r_buf[0];
                                        mouse_dx  <= signed'(r_buf[1]);
                                        mouse_dy  <= signed'(r_buf[2]);
                                    end
                                    TYP_GAME: begin
                                        game_l   <= r_buf[0][0];
                                        game_r   <= r_buf[0][1];
                                        game_u   <= r_buf[0][2];
                                        game_d   <= r_buf[0][3];
                                        game_a   <= r_buf[0][4];
                                        game_b   <= r_buf[0][5];
                                        game_x   <= r_buf[0][6];
                                        game_y   <= r_buf[0][7];
                                        game_sel <= r_buf[1][0];
                                        game_sta <= r_buf[1][1];
                                    end
                                    default: ;
                                endcase
                            end else begin
                                err <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                        end else begin
                            err     <= 1'b1;
                            r_state <= ST_SKIP;
                        end
                    end
                    ST_SKIP: begin
                        if (is_term(w_data)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        // ST_IDLE (and the transient ST_TYPE encoding)
                        if (is_term(w_data) || (w_data == ASCII_SP)) begin
                            r_state <= ST_IDLE;
                        end else if (decode_type(w_data) != TYP_NONE) begin
                            r_lineTyp <= decode_type(w_data);
                            r_byteCnt <= '0;
                            r_haveHi  <= 1'b0;
                            r_state   <= ST_DATA;
                        end else begin
                            err     <= 1'b1;
                            r_state <= ST_SKIP;
                        end
                    end
                endcase
            end else if (w_timeout) begin
                if (r_state == ST_DATA) begin
                    err <= 1'b1;
                end
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_hid_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_hid_decoder
// Directed testbench for uart_hid_decoder. A fast baud rate (12 clocks per
// bit) keeps line transfers short. Build option LINE_TIMEOUT_EN selects
// which idle-line behaviour is expected.
// -----------------------------------------------------------------------------
module tb_uart_hid_decoder;

    localparam int CLK_FREQ    = 12_000_000;
    localparam int BAUD        = 1_000_000;
    localparam int TIMEOUT_CYC = 5000;
    localparam int BIT_CYC     = 12;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              uart_rx = 1'b1;
    logic [1:0]        typ;
    logic              report;
    logic              err;
    logic [7:0]        key_modifiers, key1, key2, key3, key4;
    logic [7:0]        mouse_btn;
    logic signed [7:0] mouse_dx, mouse_dy;
    logic              game_l, game_r, game_u, game_d, game_a, game_b;
    logic              game_x, game_y, game_sel, game_sta;
    logic [9:0]        gameVec;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;
    int reportCount = 0;
    int errCount = 0;
    int overlapCount = 0;
    int longPulseCount = 0;
    logic prevReport = 1'b0;
    logic prevErr = 1'b0;
    int repBase;
    int errBase;

    uart_hid_decoder #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rx       (uart_rx),
        .typ           (typ),
        .report        (report),
        .err           (err),
        .key_modifiers (key_modifiers),
        .key1          (key1),
        .key2          (key2),
        .key3          (key3),
        .key4          (key4),
        .mouse_btn     (mouse_btn),
        .mouse_dx      (mouse_dx),
        .mouse_dy      (mouse_dy),
        .game_l        (game_l),
        .game_r        (game_r),
        .game_u        (game_u),
        .game_d        (game_d),
        .game_a        (game_a),
        .game_b        (game_b),
        .game_x        (game_x),
        .game_y        (game_y),
        .game_sel      (game_sel),
        .game_sta      (game_sta)
    );

    assign gameVec = {game_l, game_r, game_u, game_d, game_a, game_b,
                      game_x, game_y, game_sel, game_sta};

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge away from register updates:
    // counts report/err pulses, pulses longer than one cycle, and overlap.
    always @(negedge clk) begin
        if (report) reportCount++;
        if (err) errCount++;
        if (report && err) overlapCount++;
        if ((report && prevReport) || (err && prevErr)) longPulseCount++;
        prevReport = report;
        prevErr = err;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // One 8N1 frame; a bad stop bit is followed by one idle bit so the next
    // start bit has a falling edge to find.
    task automatic applyStimulus(input logic [7:0] b, input logic stopOk);
        @(negedge clk) uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rx = stopOk;
        repeat (BIT_CYC) @(negedge clk);
        uart_rx = 1'b1;
        if (!stopOk) repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic sendText(input string s);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(s[i], 1'b1);
        end
    endtask

    task automatic markCounts();
        repBase = reportCount;
        errBase = errCount;
    endtask

    task automatic checkPulses(input string tag, input int expRep, input int expErr);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_reports"}, 32'(reportCount - repBase), 32'(expRep));
        checkOutput({tag, "_errs"}, 32'(errCount - errBase), 32'(expErr));
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        checkOutput("rst_typ", {30'd0, typ}, 32'd0);
        checkOutput("rst_report", {31'd0, report}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_keys", {key_modifiers, key1, key2, key3}, 32'd0);
        checkOutput("rst_mouse", {8'd0, mouse_btn, mouse_dx, mouse_dy}, 32'd0);
        checkOutput("rst_game", {22'd0, gameVec}, 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Test 1: keyboard line with CR
        markCounts();
        sendText("K 02 04 00 00 00");
        applyStimulus(8'h0D, 1'b1);
        checkPulses("t1", 1, 0);
        checkOutput("t1_typ", {30'd0, typ}, 32'd1);
        checkOutput("t1_keys", {key_modifiers, key1, key2, key3}, 32'h02040000);
        checkOutput("t1_key4", {24'd0, key4}, 32'h00);

        // Test 2: lower-case mouse line, no spaces, LF terminator
        markCounts();
        sendText("m01ff05\n");
        checkPulses("t2", 1, 0);
        checkOutput("t2_typ", {30'd0, typ}, 32'd2);
        checkOutput("t2_mouse", {8'd0, mouse_btn, mouse_dx, mouse_dy}, 32'h0001FF05);
        checkOutput("t2_keys_held", {key_modifiers, key1, key2, key3}, 32'h02040000);

        // Test 3: gamepad line with CR LF -> one report
        markCounts();
        sendText("G 11 02");
        applyStimulus(8'h0D, 1'b1);
        applyStimulus(8'h0A, 1'b1);
        checkPulses("t3", 1, 0);
        checkOutput("t3_typ", {30'd0, typ}, 32'd3);
        checkOutput("t3_game", {22'd0, gameVec}, 32'b10_0010_0001);

        // Mixed-case hex digits on a lower-case keyboard line
        markCounts();
        sendText("k A0 b1 C2 d3 e4\n");
        checkPulses("mix", 1, 0);
        checkOutput("mix_keys", {key_modifiers, key1, key2, key3}, 32'hA0B1C2D3);
        checkOutput("mix_key4", {24'd0, key4}, 32'hE4);
        checkOutput("mix_mouse_held", {8'd0, mouse_btn, mouse_dx, mouse_dy}, 32'h0001FF05);

        // Test 4: bad character, then a good mouse line
        markCounts();
        sendText("K 02 0Z 00");
        applyStimulus(8'h0D, 1'b1);
        checkPulses("t4a", 0, 1);
        checkOutput("t4a_typ", {30'd0, typ}, 32'd1);
        checkOutput("t4a_keys", {key_modifiers, key1, key2, key3}, 32'hA0B1C2D3);
        markCounts();
        sendText("M 00 01 02");
        applyStimulus(8'h0D, 1'b1);
        checkPulses("t4b", 1, 0);
        checkOutput("t4b_mouse", {6'd0, typ, mouse_btn, mouse_dx, mouse_dy}, 32'h02000102);

        // Test 5: framing error on the 3rd byte, rest of line skipped
        markCounts();
        applyStimulus("K", 1'b1);
        applyStimulus(" ", 1'b1);
        applyStimulus("0", 1'b0);
        sendText("2 04 00 00 00");
        applyStimulus(8'h0D, 1'b1);
        checkPulses("t5a", 0, 1);
        checkOutput("t5a_keys", {key_modifiers, key1, key2, key3}, 32'hA0B1C2D3);
        markCounts();
        sendText("G 00 03\r");
        checkPulses("t5b", 1, 0);
        checkOutput("t5b_game", {20'd0, typ, gameVec}, {20'd0, 2'd3, 10'b00_0000_0011});

        // Grammar boundaries: odd nibble count, short line, overflow, bad type
        markCounts();
        sendText("M 0 01 02\r");
        checkPulses("odd", 0, 1);
        markCounts();
        sendText("G 01\r");
        checkPulses("short", 0, 1);
        markCounts();
        sendText("K 00 00 00 00 00 00\r");
        checkPulses("ovf", 0, 1);
        markCounts();
        sendText("X12\r");
        checkPulses("badtype", 0, 1);
        checkOutput("bnd_typ", {30'd0, typ}, 32'd3);

        // Empty lines and a sub-half-bit glitch are silent
        markCounts();
        sendText("\r\n \r");
        @(negedge clk) uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        checkPulses("quiet", 0, 0);
        markCounts();
        sendText("G 80 00\n");
        checkPulses("postglitch", 1, 0);
        checkOutput("postglitch_game", {22'd0, gameVec}, 32'b00_0000_0100);

        // Test 6: partial line left idle
        markCounts();
        sendText("K 02");
        repeat (4900) @(negedge clk);
        checkOutput("to_early_errs", 32'(errCount - errBase), 32'd0);
        repeat (1100) @(negedge clk);
`ifdef LINE_TIMEOUT_EN
        checkOutput("to_errs", 32'(errCount - errBase), 32'd1);
`else
        checkOutput("to_errs", 32'(errCount - errBase), 32'd0);
        applyStimulus(8'h0D, 1'b1);
        checkOutput("to_term_errs", 32'(errCount - errBase), 32'd1);
`endif
        markCounts();
        sendText("M 00 00 00\r");
        checkPulses("to_next", 1, 0);
        checkOutput("to_next_mouse", {6'd0, typ, mouse_btn, mouse_dx, mouse_dy}, 32'h02000000);

        // Async reset mid-line: line lost, outputs cleared, no pulses
        markCounts();
        sendText("K 11 22");
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        sendText("\r");
        checkPulses("midrst", 0, 0);
        checkOutput("midrst_typ", {30'd0, typ}, 32'd0);
        checkOutput("midrst_keys", {key_modifiers, key1, key2, key3}, 32'd0);

        // Pulse shape over the whole run
        checkOutput("pulse_overlap", 32'(overlapCount), 32'd0);
        checkOutput("pulse_width", 32'(longPulseCount), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
